// File: rtl/uart_pkg.sv
// Shared types and sizes for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned WORD_BYTES           = 4;
  localparam int unsigned WORD_W               = DATA_BITS * WORD_BYTES;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchronizer, start/data/stop sampling and framing check.
// Strobes are combinational on the stop-sample cycle so the wrapper can register them in step.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 i_serial,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_byte_valid_c,
  output logic                 o_frame_err_c,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 r_sync_meta;
  logic                 r_rx_s;
  rx_state_e            r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_busy;

  rx_state_e            w_state_nxt;
  logic [CNT_W-1:0]     w_clk_cnt_nxt;
  logic [IDX_W-1:0]     w_bit_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;

  // State and datapath registers; synchronizer presets to the idle-high line level.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_sync_meta <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_sync_meta <= i_serial;
      r_rx_s      <= r_sync_meta;
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clk_cnt_nxt  = r_clk_cnt + CNT_W'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    o_byte_valid_c = 1'b0;
    o_frame_err_c  = 1'b0;
    case (r_state)
      IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = START;
      end
      START: begin
        // Re-check at mid start bit to reject glitches.
        if (r_clk_cnt == CNT_MID) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_nxt          = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == IDX_LAST) w_state_nxt = STOP;
          else w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (r_rx_s) begin
            o_byte_valid_c = 1'b1;
            w_state_nxt    = IDLE;
          end else begin
            o_frame_err_c = 1'b1;
            w_state_nxt   = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        w_clk_cnt_nxt = '0;
        if (r_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_data = r_shift;
  assign o_busy = r_busy;

endmodule

// File: rtl/uart_word_rx.sv
// UART receive stage: delivers bytes, and in word mode packs 4 bytes MSB-first into a word.
// A partial word is dropped on a framing error or after TIMEOUT_CLKS idle cycles.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 i_serial,
  input  logic                 i_mode_select,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_byte_valid,
  output logic [WORD_W-1:0]    o_word,
  output logic                 o_word_valid,
  output logic                 o_frame_err,
  output logic                 o_timeout,
  output logic                 o_busy
);

  localparam int unsigned WCNT_W = $clog2(WORD_BYTES);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CLKS);
  localparam int unsigned ACC_W  = WORD_W - DATA_BITS;

  logic [DATA_BITS-1:0] w_data;
  logic                 w_byte_valid;
  logic                 w_frame_err;
  logic                 w_busy;
  logic [WCNT_W-1:0]    w_cnt_base;
  logic [WORD_W-1:0]    w_word_asm;

  logic [DATA_BITS-1:0] r_byte;
  logic                 r_byte_valid;
  logic [WORD_W-1:0]    r_word;
  logic                 r_word_valid;
  logic                 r_frame_err;
  logic                 r_timeout;
  logic [ACC_W-1:0]     r_word_acc;
  logic [WCNT_W-1:0]    r_cnt;
  logic                 r_prev_mode;
  logic [IDLE_W-1:0]    r_idle_cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .i_serial      (i_serial),
    .o_data        (w_data),
    .o_byte_valid_c(w_byte_valid),
    .o_frame_err_c (w_frame_err),
    .o_busy        (w_busy)
  );

  // A mode change restarts assembly so the new byte becomes byte 0.
  assign w_cnt_base = (i_mode_select != r_prev_mode) ? '0 : r_cnt;
  assign w_word_asm = {r_word_acc, w_data};

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_timeout    <= 1'b0;
      r_word_acc   <= '0;
      r_cnt        <= '0;
      r_prev_mode  <= 1'b0;
      r_idle_cnt   <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_word_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_frame_err  <= w_frame_err;

      if (w_busy || (r_cnt == '0)) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt == IDLE_W'(TIMEOUT_CLKS - 1)) begin
        r_idle_cnt <= '0;
        r_cnt      <= '0;
        r_timeout  <= 1'b1;
      end else begin
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end

      if (w_frame_err) r_cnt <= '0;

      if (w_byte_valid) begin
        r_byte       <= w_data;
        r_byte_valid <= 1'b1;
        r_prev_mode  <= i_mode_select;
        if (i_mode_select) begin
          r_word_acc <= w_word_asm[ACC_W-1:0];
          if (w_cnt_base == WCNT_W'(WORD_BYTES - 1)) begin
            r_word       <= w_word_asm;
            r_word_valid <= 1'b1;
            r_cnt        <= '0;
          end else begin
            r_cnt <= w_cnt_base + WCNT_W'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_frame_err  = r_frame_err;
  assign o_timeout    = r_timeout;
  assign o_busy       = w_busy;

endmodule
